// File: rtl/backend_cfg_master.sv
// Upstream configuration master for the analog backend: reset pulse, 5-bit serial
// gain frame on a divided sclk/sdin pair, then ready wait with timeout and VCO capture.
module backend_cfg_master #(
  parameter int unsigned SCLK_DIV      = 4,
  parameter int unsigned RESET_CYCLES  = 8,
  parameter int unsigned READY_TIMEOUT = 200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [2:0] i_gainA1,
  input  logic [1:0] i_gainA2,
  input  logic       i_ready,
  input  logic       i_vco1_fast,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout,
  output logic       o_vco1_fast
);

  typedef enum logic [2:0] {
    IDLE, RST, SHIFT_LO, SHIFT_HI, WAIT_RDY, FINISH
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0] TO_LAST  = 8'(READY_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] frame_q, frame_d;
  logic       resetb_q, resetb_d;
  logic       sclk_q, sclk_d;
  logic       sdin_q, sdin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmo_q, tmo_d;
  logic       vco_q, vco_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    resetb_d = resetb_q;
    sclk_d   = sclk_q;
    sdin_d   = sdin_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    vco_d    = vco_q;
    unique case (state_q)
      IDLE, FINISH: begin
        if (i_start) begin
          frame_d  = {i_gainA1, i_gainA2};
          busy_d   = 1'b1;
          done_d   = 1'b0;
          tmo_d    = 1'b0;
          resetb_d = 1'b0;
          sclk_d   = 1'b0;
          cnt_d    = 8'd0;
          state_d  = RST;
        end
      end
      RST: begin
        if (cnt_q == RST_LAST) begin
          resetb_d = 1'b1;
          sdin_d   = frame_q[4];
          cnt_d    = 8'd0;
          bit_d    = 3'd0;
          state_d  = SHIFT_LO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = 8'd0;
          // sdin only moves on the falling edge, so it is settled before each rise
          if (bit_q == 3'd4) begin
            sdin_d  = 1'b0;
            state_d = WAIT_RDY;
          end else begin
            frame_d = frame_q << 1;
            sdin_d  = frame_q[3];
            bit_d   = bit_q + 3'd1;
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_RDY: begin
        if (i_ready) begin
          vco_d   = i_vco1_fast;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else if (cnt_q == TO_LAST) begin
          // park the backend in reset when it never came up
          tmo_d    = 1'b1;
          busy_d   = 1'b0;
          resetb_d = 1'b0;
          state_d  = FINISH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      resetb_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdin_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      vco_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      resetb_q <= resetb_d;
      sclk_q   <= sclk_d;
      sdin_q   <= sdin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      vco_q    <= vco_d;
    end
  end

  always_ff @(posedge i_clk) begin
    frame_q <= frame_d;
  end

  assign o_resetbAll = resetb_q;
  assign o_sclk      = sclk_q;
  assign o_sdin      = sdin_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = tmo_q;
  assign o_vco1_fast = vco_q;

endmodule

// File: tb/tb_backend_cfg_master.sv
// Bench for backend_cfg_master: default instance plus a fast (1/1/6) instance,
// each compared cycle by cycle against an arithmetic waveform model.
module tb_backend_cfg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, ready, vcoin;
  logic [2:0] ga1 [2];
  logic [1:0] ga2 [2];
  logic [1:0] rb, sclk, sdin, busy, done, tmo, vco;

  int n_cmp = 0;
  int n_bad = 0;
  int RC [2] = '{8, 1};
  int SD [2] = '{4, 1};
  int TO [2] = '{200, 6};
  logic last_vco [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  backend_cfg_master dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start[0]),
    .i_gainA1(ga1[0]), .i_gainA2(ga2[0]), .i_ready(ready[0]), .i_vco1_fast(vcoin[0]),
    .o_resetbAll(rb[0]), .o_sclk(sclk[0]), .o_sdin(sdin[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_timeout(tmo[0]), .o_vco1_fast(vco[0])
  );

  backend_cfg_master #(.SCLK_DIV(1), .RESET_CYCLES(1), .READY_TIMEOUT(6)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start[1]),
    .i_gainA1(ga1[1]), .i_gainA2(ga2[1]), .i_ready(ready[1]), .i_vco1_fast(vcoin[1]),
    .o_resetbAll(rb[1]), .o_sclk(sclk[1]), .o_sdin(sdin[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_timeout(tmo[1]), .o_vco1_fast(vco[1])
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs(input int w);
    return {rb[w], sclk[w], sdin[w], busy[w], done[w], tmo[w], vco[w]};
  endfunction

  // r: edges after WAIT_RDY entry at which ready is sampled high (0 = never)
  // intr_j: sample index at which a spurious start is driven (-1 = none)
  // rst_j: sample index at which i_reset is driven (-1 = none)
  task automatic run_frame(input int w, input logic [2:0] a1, input logic [1:0] a2,
                           input int r, input logic v, input int intr_j, input int rst_j);
    int rc = RC[w];
    int sd = SD[w];
    int to = TO[w];
    int wj = rc + 10 * sd;
    bit ok = (r >= 1 && r <= to);
    int jend = ok ? wj + r : wj + to;
    int last = (rst_j >= 0) ? rst_j + 6 : jend + 3;
    logic [4:0] fr = {a1, a2};
    int rises = 0;
    logic [4:0] bits = 5'd0;
    logic prev_sclk = 1'b0;
    logic e_rb, e_sclk, e_sdin, e_busy, e_done, e_tmo, e_vco;
    int k, b;

    start[w] = 1'b1; ga1[w] = a1; ga2[w] = a2; ready[w] = 1'b0; vcoin[w] = ~v;
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      start[w] = 1'b0;
      if (rst_j >= 0 && j > rst_j) begin
        {e_rb, e_sclk, e_sdin, e_busy, e_done, e_tmo, e_vco} = 7'd0;
      end else begin
        e_rb = (j < rc) ? 1'b0 : ((!ok && j >= jend) ? 1'b0 : 1'b1);
        e_sclk = 1'b0;
        e_sdin = 1'b0;
        if (j >= rc && j < wj) begin
          k = j - rc;
          b = k / (2 * sd);
          e_sclk = ((k % (2 * sd)) >= sd);
          e_sdin = fr[4 - b];
        end
        e_busy = (j < jend);
        e_done = ok && (j >= jend);
        e_tmo  = !ok && (j >= jend);
        e_vco  = (ok && j >= jend) ? v : last_vco[w];
      end
      chk_eq($sformatf("dut%0d frame %02h j=%0d {rb,sclk,sdin,busy,done,tmo,vco}", w, fr, j),
             32'(outs(w)), 32'({e_rb, e_sclk, e_sdin, e_busy, e_done, e_tmo, e_vco}));
      if (sclk[w] && !prev_sclk) begin
        rises++;
        bits = {bits[3:0], sdin[w]};
      end
      prev_sclk = sclk[w];
      ready[w] = (r >= 1) && (j + 1 == wj + r);
      vcoin[w] = ready[w] ? v : ~v;
      if (j == intr_j) begin
        start[w] = 1'b1; ga1[w] = ~a1; ga2[w] = ~a2;
      end
      if (j == rst_j) rst = 1'b1;
      if (j == rst_j + 1) rst = 1'b0;
    end
    ready[w] = 1'b0;
    if (rst_j >= 0) begin
      chk_eq($sformatf("dut%0d sclk rises before reset", w), rises, 3);
      last_vco[0] = 1'b0;
      last_vco[1] = 1'b0;
    end else begin
      chk_eq($sformatf("dut%0d sclk rises", w), rises, 5);
      chk_eq($sformatf("dut%0d bits at rises", w), 32'(bits), 32'(fr));
      if (ok) last_vco[w] = v;
    end
  endtask

  initial begin
    int w, r;
    rst = 1'b1; start = 2'b00; ready = 2'b00; vcoin = 2'b00;
    ga1[0] = 3'd0; ga1[1] = 3'd0; ga2[0] = 2'd0; ga2[1] = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("dut0 reset outputs", 32'(outs(0)), 32'd0);
    chk_eq("dut1 reset outputs", 32'(outs(1)), 32'd0);
    rst = 1'b0;

    run_frame(0, 3'b101, 2'b10, 30, 1'b1, -1, -1);
    run_frame(0, 3'b111, 2'b11, 30, 1'b1, -1, -1);
    run_frame(0, 3'b010, 2'b01, 0, 1'b0, -1, -1);
    run_frame(0, 3'b110, 2'b01, 200, 1'b1, -1, -1);
    run_frame(0, 3'b100, 2'b11, 5, 1'b0, 8 + 16 + 4, -1);
    run_frame(0, 3'b011, 2'b00, 7, 1'b1, -1, -1);
    run_frame(0, 3'b101, 2'b01, 10, 1'b1, -1, 8 + 5 * 4);
    run_frame(0, 3'b001, 2'b10, 3, 1'b1, -1, -1);

    run_frame(1, 3'b101, 2'b10, 2, 1'b1, -1, -1);
    run_frame(1, 3'b011, 2'b11, 0, 1'b0, -1, -1);
    run_frame(1, 3'b110, 2'b00, 6, 1'b1, -1, -1);
    run_frame(1, 3'b001, 2'b01, 7, 1'b1, -1, -1);
    run_frame(1, 3'b111, 2'b10, 1, 1'b0, 1 + 4 + 1, -1);
    run_frame(1, 3'b010, 2'b10, 4, 1'b1, -1, 1 + 5);
    run_frame(1, 3'b100, 2'b01, 1, 1'b1, -1, -1);

    for (int i = 0; i < 12; i++) begin
      w = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, TO[w] + 2));
      if (w == 0 && r > 40 && r < 195) r = r % 40;
      run_frame(w, 3'($urandom), 2'($urandom), r, 1'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/backend_cfg_master.md
Name: backend_cfg_master

Overview:
Upstream controller for the analog backend sequencer. On a start request it:
- holds the backend in reset (drives its active-low global reset);
- releases the reset and serially shifts the 5-bit gain frame (gainA1[2:0], gainA2[1:0]) MSB-first on a divided serial clock/data pair;
- waits for the backend's ready flag with a timeout, then captures the VCO-compare result.

It sits between the digital control/register logic and the backend's i_resetbAll/i_sclk/i_sdin/o_ready/o_vco1_fast pins.

Parameters:
SCLK_DIV, 4, i_clk cycles per o_sclk half-period; legal 1..255.
RESET_CYCLES, 8, i_clk cycles o_resetbAll is held low after start; legal 1..255.
READY_TIMEOUT, 200, max i_clk cycles to wait for i_ready after the frame; legal 1..255.

Ports:
i_clk  input  1  system clock; all logic on posedge.
i_reset  input  1  synchronous, active-high reset.
i_start  input  1  one-cycle start request; sampled only when not busy.
i_gainA1  input  3  amplifier 1 gain; latched on accepted start.
i_gainA2  input  2  amplifier 2 gain; latched on accepted start.
i_ready  input  1  backend ready flag (backend o_ready).
i_vco1_fast  input  1  backend VCO compare result (backend o_vco1_fast).
o_resetbAll  output  1  active-low reset to backend.
o_sclk  output  1  serial clock to backend; idles low.
o_sdin  output  1  serial data to backend.
o_busy  output  1  high from accepted start until done/timeout.
o_done  output  1  level; backend reported ready; held until next accepted start.
o_timeout  output  1  level; ready not seen within READY_TIMEOUT; held until next accepted start.
o_vco1_fast  output  1  i_vco1_fast captured when ready is seen.

Behaviour:
- Reset (i_reset=1 at posedge): o_resetbAll=0, o_sclk=0, o_sdin=0, o_busy=0, o_done=0, o_timeout=0, o_vco1_fast=0; FSM to IDLE; all counters cleared. Mid-operation reset aborts the frame on that edge, with no partial sclk pulse afterwards.
- States: IDLE, RST, SHIFT_LO, SHIFT_HI, WAIT_RDY, FINISH.
- IDLE/FINISH + i_start=1:
  - latch frame = {i_gainA1, i_gainA2} into 5-bit shift register;
  - o_busy=1, o_done=0, o_timeout=0, o_resetbAll=0;
  - go to RST.
- i_start while o_busy=1 is ignored; frame inputs are not re-sampled.
- RST: hold o_resetbAll=0 for RESET_CYCLES cycles, then o_resetbAll=1, o_sdin=frame[4], and go to SHIFT_LO.
- SHIFT_LO:
  - o_sclk=0 for SCLK_DIV cycles, then o_sclk=1 and go to SHIFT_HI.
  - o_sdin changes only on entry to SHIFT_LO, so it is stable across each rising edge.
- SHIFT_HI: o_sclk=1 for SCLK_DIV cycles, then o_sclk=0:
  - bits remain: shift left, o_sdin=next bit, go to SHIFT_LO;
  - after 5th bit: o_sdin=0, go to WAIT_RDY.
  - Exactly 5 o_sclk rising edges per frame, never more.
- Timing from start accepted at edge N, with defaults 8/4:
  - o_resetbAll low cycles N+1..N+8 (general: N+1..N+RESET_CYCLES); rises at N+9 (general: N+1+RESET_CYCLES), together with sdin=bit4.
  - First sclk rise at N+13 (general: +SCLK_DIV).
  - Bit period 2*SCLK_DIV.
  - Last sclk fall at N+49 (general: N+1+RESET_CYCLES+10*SCLK_DIV); WAIT_RDY entered then.
- WAIT_RDY: 8-bit wait counter increments each cycle.
  - i_ready=1 sampled: o_vco1_fast<=i_vco1_fast, o_done=1, o_busy=0, go to FINISH.
  - Else if counter reaches READY_TIMEOUT: o_timeout=1, o_busy=0, o_resetbAll=0 (park backend), go to FINISH.
  - i_ready=1 in the expiry cycle: ready wins, no timeout.
- FINISH: outputs held; o_resetbAll stays 1 after success, 0 after timeout. A new i_start restarts the full sequence, including the reset phase.
- o_done and o_timeout are never simultaneously 1.
- Counter widths are 8 bits; parameters outside their legal range are illegal (no runtime check).

Test Plan:
- Basic frame, defaults: gainA1=3'b101, gainA2=2'b10, start at N → o_resetbAll low N+1..N+8; sdin sequence across the 5 sclk rises = 1,0,1,1,0; first rise N+13; WAIT_RDY at N+49.
- Ready response: frame 5'b11111 as above; i_ready=1 with i_vco1_fast=1 asserted 30 cycles after frame end → o_done=1, o_busy=0, o_vco1_fast=1 next cycle; o_resetbAll stays 1.
- Timeout: i_ready held 0 → o_timeout=1 exactly 200 cycles after WAIT_RDY entry; o_resetbAll=0, o_done=0. Separate run with i_ready=1 on the expiry cycle → o_done=1, o_timeout=0.
- Start while busy: pulse i_start with different gains during SHIFT_HI of bit 2 → frame unchanged, exactly 5 sclk rises; second start after FINISH → full new sequence including 8-cycle reset.
- Mid-frame reset: assert i_reset after the 3rd sclk rise → next edge all outputs at reset values, no further sclk edges; subsequent start produces a clean 5-bit frame.
- Parameter sweep: SCLK_DIV=1, RESET_CYCLES=1 → sclk period 2 cycles, o_resetbAll low exactly 1 cycle, last sclk fall at N+12.
